pipelined_decoder: RTL and testbench
====================================

Name: pipelined_decoder

Overview:
- Parametrised, pipelined successor to the single-cycle LEGv8 instruction controller.
- Accepts 32-bit instructions over a valid/ready handshake and fully decodes opcode fields (not individual bits) in one registered stage.
- Queues decoded control bundles in a DEPTH-entry FIFO toward operand prep / ALU.
- Supports flush on taken branch and flags illegal encodings.

Parameters:
- DEPTH, 4, decoded-bundle FIFO entries; power of 2, minimum 2.
- REG_ADDR_W, 5, register index width; instruction fields are zero-extended or truncated to this width.
- ALU_CODE_W, 4, width of aluControlCode.

Ports:
- clock  in  1  main clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard the decode stage and all FIFO contents.
- in_valid  in  1  instruction present.
- in_ready  out  1  decoder can accept this cycle.
- instruction  in  32  instruction word.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag  out  1 each  head control flags.
- aluControlCode  out  ALU_CODE_W  head ALU operation.
- readRegister1, readRegister2, writeRegister  out  REG_ADDR_W each  head register indices.
- illegal  out  1  head instruction unrecognised.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high): decode stage empty; FIFO empty; count=0; out_valid=0; all head fields 0; in_ready=1 in the first cycle after reset deasserts.
- Decode table (opcode bits, resulting flags, aluControlCode):
  - ADD [31:21]=10001011000: regWrite, ALU 0010.
  - SUB 11001011000: regWrite, ALU 0110.
  - AND 10001010000: regWrite, ALU 0000.
  - ORR 10101010000: regWrite, ALU 0001.
  - LDUR 11111000010: memRead, memToReg, aluSRC, regWrite, ALU 0010.
  - STUR 11111000000: memWrite, aluSRC, ALU 0010.
  - CBZ [31:24]=10110100 and CBNZ 10110101: branch, ALU 0111.
  - B [31:26]=000101: unconditionalBranch, ALU 0111.
  - MOVZ [31:23]=110100101: aluSRC, regWrite, ALU 1101.
- Register fields:
  - readRegister1 = [9:5].
  - readRegister2 = [4:0] for STUR/CBZ/CBNZ, otherwise [20:16].
  - writeRegister = [4:0].
- Illegal instruction (no match): illegal=1, every flag 0, ALU 0000, register fields still extracted.
- Latency: accepted in cycle N → decode register valid at N+1 → written into FIFO at N+1 edge, so out_valid asserts by N+2 when the FIFO was empty. No bypass path.
- Accept condition: in_valid && in_ready.
  - in_ready = !decode_valid || fifo_has_room_after_pop.
  - fifo_has_room_after_pop = (count<DEPTH) || (out_valid && out_ready).
- Pop: out_valid && out_ready. Head fields remain stable while out_valid && !out_ready.
- Simultaneous push and pop at full: allowed; count unchanged.
- Push/pop at empty: no bypass. The pop is ignored because out_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy exactly, 0..DEPTH.
- flush:
  - Takes priority over everything else: the decode register and FIFO empty, count=0 next cycle.
  - A handshake in the flush cycle is dropped.
  - in_ready may stay high during flush.
- reset while the FIFO is non-empty: identical to the power-up reset state next cycle.

Optional Feature:
- Macro DECODE_STALL_ON_ILLEGAL_EN.
- When defined:
  - An illegal instruction reaching the decode register sets a sticky stall.
  - in_ready=0 until flush or reset.
  - The illegal bundle is still enqueued so the consumer can trap.
- When undefined: illegal bundles flow through like any other; no stall.

Test Plan:
- Reset/idle: hold reset 2 cycles → out_valid=0, count=0, in_ready=1; all flags 0.
- Single LDUR 0xF84083E1 sent with out_ready=1 → out_valid at accept+2; memRead=memToReg=aluSRC=regWriteFlag=1, ALU 0010, readRegister1=31, writeRegister=1.
- Fill/backpressure: out_ready=0, stream ADD, SUB, AND, ORR, B (DEPTH=4) →
  - count reaches 4 with the fifth held in the decode stage; in_ready=0.
  - Head stays ADD (ALU 0010).
  - Raise out_ready → order ADD, SUB(0110), AND(0000), ORR(0001), B(unconditionalBranch=1) with no loss or duplication.
- Full + simultaneous push/pop: keep full, out_ready=1, in_valid=1 → count stays 4 every cycle; throughput 1 per cycle.
- Flush mid-stream: 3 entries queued, assert flush together with an in_valid handshake → next cycle count=0, out_valid=0; the flushed-cycle instruction never appears.
- Illegal + CBZ: send 0x00000000 then CBZ 0xB4000045 →
  - First bundle illegal=1, all flags 0.
  - CBZ bundle branch=1, ALU 0111, readRegister2=5.
  - With DECODE_STALL_ON_ILLEGAL_EN, CBZ is not accepted (in_ready=0) until flush.

Source files
------------

// File: rtl/pipelined_decoder.sv
// rtl/pipelined_decoder.sv - LEGv8 opcode decode stage feeding a DEPTH-entry control-bundle FIFO
// Optional build macro DECODE_STALL_ON_ILLEGAL_EN: an illegal decode holds in_ready low until flush/reset.
module pipelined_decoder #(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CODE_W = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             instruction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    unconditionalBranch,
  output logic                    branch,
  output logic                    memRead,
  output logic                    memToReg,
  output logic                    memWrite,
  output logic                    aluSRC,
  output logic                    regWriteFlag,
  output logic [ALU_CODE_W-1:0]   aluControlCode,
  output logic [REG_ADDR_W-1:0]   readRegister1,
  output logic [REG_ADDR_W-1:0]   readRegister2,
  output logic [REG_ADDR_W-1:0]   writeRegister,
  output logic                    illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                  unconditionalBranch;
    logic                  branch;
    logic                  memRead;
    logic                  memToReg;
    logic                  memWrite;
    logic                  aluSRC;
    logic                  regWriteFlag;
    logic [ALU_CODE_W-1:0] aluControlCode;
    logic [REG_ADDR_W-1:0] readRegister1;
    logic [REG_ADDR_W-1:0] readRegister2;
    logic [REG_ADDR_W-1:0] writeRegister;
    logic                  illegal;
  } bundle_t;

  bundle_t             decoded;
  bundle_t             decBundle;
  logic                decValid;
  logic                useRtAsRead2;
  bundle_t             fifoMem [DEPTH];
  bundle_t             head;
  logic [PTR_W-1:0]    wrPtr;
  logic [PTR_W-1:0]    rdPtr;
  logic                pop;
  logic                push;
  logic                roomAfterPop;
  logic                accept;
  logic                unusedImmBits;

  // Immediate/shift bits [15:10] carry no control information for this decoder.
  assign unusedImmBits = ^instruction[15:10];

  always_comb begin
    decoded      = '0;
    useRtAsRead2 = 1'b0;
    if (instruction[31:21] == 11'b10001011000) begin
      decoded.regWriteFlag   = 1'b1;
      decoded.aluControlCode = ALU_CODE_W'(4'b0010);
    end else if (instruction[31:21] == 11'b11001011000) begin
      decoded.regWriteFlag   = 1'b1;
      decoded.aluControlCode = ALU_CODE_W'(4'b0110);
    end else if (instruction[31:21] == 11'b10001010000) begin
      decoded.regWriteFlag   = 1'b1;
      decoded.aluControlCode = ALU_CODE_W'(4'b0000);
    end else if (instruction[31:21] == 11'b10101010000) begin
      decoded.regWriteFlag   = 1'b1;
      decoded.aluControlCode = ALU_CODE_W'(4'b0001);
    end else if (instruction[31:21] == 11'b11111000010) begin
      decoded.memRead        = 1'b1;
      decoded.memToReg       = 1'b1;
      decoded.aluSRC         = 1'b1;
      decoded.regWriteFlag   = 1'b1;
      decoded.aluControlCode = ALU_CODE_W'(4'b0010);
    end else if (instruction[31:21] == 11'b11111000000) begin
      decoded.memWrite       = 1'b1;
      decoded.aluSRC         = 1'b1;
      decoded.aluControlCode = ALU_CODE_W'(4'b0010);
      useRtAsRead2           = 1'b1;
    end else if (instruction[31:25] == 7'b1011010) begin
      // CBZ and CBNZ differ only in bit 24; both read Rt for the zero test.
      decoded.branch         = 1'b1;
      decoded.aluControlCode = ALU_CODE_W'(4'b0111);
      useRtAsRead2           = 1'b1;
    end else if (instruction[31:26] == 6'b000101) begin
      decoded.unconditionalBranch = 1'b1;
      decoded.aluControlCode      = ALU_CODE_W'(4'b0111);
    end else if (instruction[31:23] == 9'b110100101) begin
      decoded.aluSRC         = 1'b1;
      decoded.regWriteFlag   = 1'b1;
      decoded.aluControlCode = ALU_CODE_W'(4'b1101);
    end else begin
      decoded.illegal = 1'b1;
    end
    decoded.readRegister1 = REG_ADDR_W'(instruction[9:5]);
    decoded.writeRegister = REG_ADDR_W'(instruction[4:0]);
    decoded.readRegister2 = useRtAsRead2 ? REG_ADDR_W'(instruction[4:0])
                                         : REG_ADDR_W'(instruction[20:16]);
  end

  assign out_valid    = (count != '0);
  assign pop          = out_valid && out_ready;
  assign roomAfterPop = (count < CNT_W'(DEPTH)) || pop;
  assign push         = decValid && roomAfterPop;
  assign accept       = in_valid && in_ready;

`ifdef DECODE_STALL_ON_ILLEGAL_EN
  logic stalled;
  assign in_ready = !stalled && (!decValid || roomAfterPop);
`else
  assign in_ready = !decValid || roomAfterPop;
`endif

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      decValid  <= 1'b0;
      decBundle <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
`ifdef DECODE_STALL_ON_ILLEGAL_EN
      stalled   <= 1'b0;
`endif
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= decBundle;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (accept) begin
        decValid  <= 1'b1;
        decBundle <= decoded;
      end else if (push) begin
        decValid  <= 1'b0;
      end
`ifdef DECODE_STALL_ON_ILLEGAL_EN
      if (accept && decoded.illegal) begin
        stalled <= 1'b1;
      end
`endif
    end
  end

  // Head reads as all-zero whenever the FIFO is empty so stale slots never leak out.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = fifoMem[rdPtr];
    end
  end

  assign unconditionalBranch = head.unconditionalBranch;
  assign branch              = head.branch;
  assign memRead             = head.memRead;
  assign memToReg            = head.memToReg;
  assign memWrite            = head.memWrite;
  assign aluSRC              = head.aluSRC;
  assign regWriteFlag        = head.regWriteFlag;
  assign aluControlCode      = head.aluControlCode;
  assign readRegister1       = head.readRegister1;
  assign readRegister2       = head.readRegister2;
  assign writeRegister       = head.writeRegister;
  assign illegal             = head.illegal;

endmodule

// File: tb/tb_pipelined_decoder.sv
// tb/tb_pipelined_decoder.sv - table vectors, corner sequences and random traffic against a queue model
module tb_pipelined_decoder;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instruction;
  logic        ub, br, mr, m2r, mw, asrc, rw, illegalOut;
  logic [3:0]  alu;
  logic [4:0]  rr1, rr2, wr;
  logic [2:0]  count;

  always #5 clock = ~clock;

  pipelined_decoder #(.DEPTH(4), .REG_ADDR_W(5), .ALU_CODE_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .unconditionalBranch(ub), .branch(br), .memRead(mr), .memToReg(m2r),
    .memWrite(mw), .aluSRC(asrc), .regWriteFlag(rw), .aluControlCode(alu),
    .readRegister1(rr1), .readRegister2(rr2), .writeRegister(wr),
    .illegal(illegalOut), .count(count)
  );

  typedef struct packed {
    logic [6:0] flags;
    logic [3:0] alu;
    logic [4:0] rr1;
    logic [4:0] rr2;
    logic [4:0] wr;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    exp_t        exp;
  } vec_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [6:0]  flags;
    logic [3:0]  alu;
    logic        rtIsRr2;
  } rule_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model[$];
  logic        lastAccept;
  rule_t       rules[10];
  vec_t        vecs[12];

  function automatic exp_t mk(input logic [6:0] f, input logic [3:0] a, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] w, input logic il);
    exp_t e;
    e.flags = f; e.alu = a; e.rr1 = r1; e.rr2 = r2; e.wr = w; e.ill = il;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t e;
    e.flags = {ub, br, mr, m2r, mw, asrc, rw};
    e.alu = alu; e.rr1 = rr1; e.rr2 = rr2; e.wr = wr; e.ill = illegalOut;
    return e;
  endfunction

  function automatic exp_t refDecode(input logic [31:0] ins);
    exp_t e;
    e = mk(7'd0, 4'd0, ins[9:5], ins[20:16], ins[4:0], 1'b1);
    foreach (rules[i]) begin
      if ((ins & rules[i].mask) == rules[i].match) begin
        e.flags = rules[i].flags;
        e.alu   = rules[i].alu;
        e.ill   = 1'b0;
        if (rules[i].rtIsRr2) e.rr2 = ins[4:0];
      end
    end
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkHead(input string name, input exp_t e);
    checkVal(name, 32'(actual()), 32'(e));
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
    int sz;
    in_valid = iv; instruction = ins; out_ready = ordy; flush = fl;
    @(negedge clock);
    lastAccept = iv && in_ready && !fl;
    sz = model.size();
    checkVal("occupancy", 32'(int'(count) <= sz && sz <= int'(count) + 1), 32'd1);
    if (!fl && out_valid && ordy) begin
      if (model.size() == 0) checkVal("pop_unexpected", 32'(out_valid), 32'd0);
      else checkHead("pop_order", refDecode(model.pop_front()));
    end
    if (fl) model.delete();
    else if (lastAccept) model.push_back(ins);
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] randLegal();
    rule_t r;
    r = rules[$urandom_range(0, 9)];
    return r.match | ($urandom & ~r.mask);
  endfunction

  initial begin
    rules[0] = '{32'hFFE00000, 32'h8B000000, 7'b0000001, 4'b0010, 1'b0};
    rules[1] = '{32'hFFE00000, 32'hCB000000, 7'b0000001, 4'b0110, 1'b0};
    rules[2] = '{32'hFFE00000, 32'h8A000000, 7'b0000001, 4'b0000, 1'b0};
    rules[3] = '{32'hFFE00000, 32'hAA000000, 7'b0000001, 4'b0001, 1'b0};
    rules[4] = '{32'hFFE00000, 32'hF8400000, 7'b0011011, 4'b0010, 1'b0};
    rules[5] = '{32'hFFE00000, 32'hF8000000, 7'b0000110, 4'b0010, 1'b1};
    rules[6] = '{32'hFF000000, 32'hB4000000, 7'b0100000, 4'b0111, 1'b1};
    rules[7] = '{32'hFF000000, 32'hB5000000, 7'b0100000, 4'b0111, 1'b1};
    rules[8] = '{32'hFC000000, 32'h14000000, 7'b1000000, 4'b0111, 1'b0};
    rules[9] = '{32'hFF800000, 32'hD2800000, 7'b0000011, 4'b1101, 1'b0};

    vecs[0]  = '{32'hF84083E1, mk(7'b0011011, 4'b0010, 5'd31, 5'd0,  5'd1,  1'b0)};
    vecs[1]  = '{32'hB4000045, mk(7'b0100000, 4'b0111, 5'd2,  5'd5,  5'd5,  1'b0)};
    vecs[2]  = '{32'h00000000, mk(7'b0000000, 4'b0000, 5'd0,  5'd0,  5'd0,  1'b1)};
    vecs[3]  = '{32'h8B020023, mk(7'b0000001, 4'b0010, 5'd1,  5'd2,  5'd3,  1'b0)};
    vecs[4]  = '{32'hCB0400A6, mk(7'b0000001, 4'b0110, 5'd5,  5'd4,  5'd6,  1'b0)};
    vecs[5]  = '{32'h8A070109, mk(7'b0000001, 4'b0000, 5'd8,  5'd7,  5'd9,  1'b0)};
    vecs[6]  = '{32'hAA0A016C, mk(7'b0000001, 4'b0001, 5'd11, 5'd10, 5'd12, 1'b0)};
    vecs[7]  = '{32'hF81003E2, mk(7'b0000110, 4'b0010, 5'd31, 5'd2,  5'd2,  1'b0)};
    vecs[8]  = '{32'hB5000027, mk(7'b0100000, 4'b0111, 5'd1,  5'd7,  5'd7,  1'b0)};
    vecs[9]  = '{32'h17FFFFFF, mk(7'b1000000, 4'b0111, 5'd31, 5'd31, 5'd31, 1'b0)};
    vecs[10] = '{32'hD28000E4, mk(7'b0000011, 4'b1101, 5'd7,  5'd0,  5'd4,  1'b0)};
    vecs[11] = '{32'h8B200023, mk(7'b0000000, 4'b0000, 5'd1,  5'd0,  5'd3,  1'b1)};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checkVal("reset_out_valid", 32'(out_valid), 32'd0);
    checkVal("reset_count", 32'(count), 32'd0);
    checkVal("reset_in_ready", 32'(in_ready), 32'd1);
    checkHead("reset_head", '0);

    // Single-instruction latency and field decode for every table entry.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].ins, 1'b0, 1'b0);
      checkVal($sformatf("vec%0d_accept", i), 32'(lastAccept), 32'd1);
      checkVal($sformatf("vec%0d_lat1", i), 32'(out_valid), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0);
      checkVal($sformatf("vec%0d_lat2", i), 32'(out_valid), 32'd1);
      checkHead($sformatf("vec%0d_fields", i), vecs[i].exp);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
    end

    // Fill under backpressure: four in the FIFO, the fifth parked in decode.
    for (int i = 3; i <= 6; i++) step(1'b1, vecs[i].ins, 1'b0, 1'b0);
    step(1'b1, vecs[9].ins, 1'b0, 1'b0);
    checkVal("fill_last_accept", 32'(lastAccept), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    checkVal("fill_count", 32'(count), 32'd4);
    checkVal("fill_in_ready", 32'(in_ready), 32'd0);
    checkHead("fill_head_add", vecs[3].exp);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    checkVal("fill_drained", 32'(model.size()), 32'd0);
    checkVal("fill_drained_valid", 32'(out_valid), 32'd0);

    // Full with simultaneous push and pop every cycle.
    for (int i = 3; i <= 6; i++) step(1'b1, vecs[i].ins, 1'b0, 1'b0);
    step(1'b1, vecs[9].ins, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, randLegal(), 1'b1, 1'b0);
      checkVal("full_accept", 32'(lastAccept), 32'd1);
      checkVal("full_count", 32'(count), 32'd4);
    end
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    checkVal("full_drained", 32'(model.size()), 32'd0);

    // Flush with a concurrent handshake.
    for (int i = 3; i <= 5; i++) step(1'b1, vecs[i].ins, 1'b0, 1'b0);
    step(1'b1, vecs[10].ins, 1'b0, 1'b0);
    step(1'b1, vecs[7].ins, 1'b1, 1'b1);
    checkVal("flush_count", 32'(count), 32'd0);
    checkVal("flush_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checkVal("flush_no_ghost", 32'(out_valid), 32'd0);

    // Reset while non-empty.
    for (int i = 3; i <= 5; i++) step(1'b1, vecs[i].ins, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    model.delete();
    checkVal("midreset_count", 32'(count), 32'd0);
    checkVal("midreset_out_valid", 32'(out_valid), 32'd0);
    checkVal("midreset_in_ready", 32'(in_ready), 32'd1);
    checkHead("midreset_head", '0);

    // Illegal word followed by CBZ.
    step(1'b1, 32'h00000000, 1'b0, 1'b0);
    step(1'b1, vecs[1].ins, 1'b0, 1'b0);
`ifdef DECODE_STALL_ON_ILLEGAL_EN
    checkVal("cbz_after_illegal_accept", 32'(lastAccept), 32'd0);
`else
    checkVal("cbz_after_illegal_accept", 32'(lastAccept), 32'd1);
`endif
    checkHead("illegal_head", vecs[2].exp);
    step(1'b0, '0, 1'b1, 1'b0);
`ifdef DECODE_STALL_ON_ILLEGAL_EN
    checkVal("stall_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, vecs[1].ins, 1'b0, 1'b0);
    checkVal("stall_cbz_blocked", 32'(lastAccept), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, vecs[1].ins, 1'b0, 1'b0);
    checkVal("stall_cbz_after_flush", 32'(lastAccept), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0);
`endif
    checkHead("cbz_head", vecs[1].exp);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) == 0) ? $urandom : randLegal(),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);
    checkVal("random_drained", 32'(model.size()), 32'd0);
    checkVal("random_out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
